// File: rtl/fp_accumulator.sv
// Running IEEE-754 single-precision accumulator with a five-state multi-cycle adder.
// Round toward zero, flush-to-zero for denormals, sticky overflow and NaN flags.
module fp_accumulator #(
    parameter int unsigned COUNT_W = 8,
    parameter int unsigned GUARD_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               clear,
    output logic [31:0]        acc_out,
    output logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               ovf,
    output logic               nan_flag
);

    localparam int unsigned SW   = 24 + GUARD_W;
    localparam int unsigned LZ_W = $clog2(SW + 1);
    localparam logic [7:0]  SW8  = 8'(SW);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, WRITE} state_t;
    typedef enum logic [1:0] {SPEC_NONE, SPEC_INF, SPEC_NAN} spec_t;

    state_t state, state_next;
    logic   ready_en;

    // Captured operand and per-stage registers
    logic [31:0]   operand;
    logic [SW-1:0] al_sig_a, al_sig_b;
    logic          al_sign_a, al_sign_b;
    logic [7:0]    al_exp;
    spec_t         al_spec;
    logic          al_spec_sign;
    logic [SW:0]   sum_mag;
    logic          sum_sign;
    logic [SW-1:0] nm_sig;
    logic [9:0]    nm_exp;
    logic          nm_sign, nm_zero, nm_over;

    // ALIGN combinational signals
    logic          a_sign, b_sign;
    logic [7:0]    a_exp, b_exp, exp_diff, big_exp;
    logic [22:0]   a_frac, b_frac;
    logic          a_nan, b_nan, a_inf, b_inf;
    logic [SW-1:0] a_ext, b_ext, sig_a_al, sig_b_al;
    spec_t         spec_c;
    logic          spec_sign_c;

    // ADD / NORM combinational signals
    logic [SW:0]     add_mag;
    logic            add_sign;
    logic [LZ_W-1:0] lz;
    logic            lz_found;
    logic [SW-1:0]   norm_sig_c;
    logic [9:0]      norm_exp_c;
    logic            norm_zero_c, norm_under_c, norm_over_c;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid && in_ready) state_next = ALIGN;
                ALIGN:   state_next = ADD;
                ADD:     state_next = NORM;
                NORM:    state_next = WRITE;
                WRITE:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ready_en keeps in_ready low until the first edge after reset releases
    always_comb begin
        busy     = (state != IDLE);
        in_ready = ready_en && (state == IDLE) && !clear;
    end

    // ---------------- ALIGN ----------------
    always_comb begin
        a_sign = acc_out[31];
        a_exp  = acc_out[30:23];
        a_frac = acc_out[22:0];
        b_sign = operand[31];
        b_exp  = operand[30:23];
        b_frac = operand[22:0];

        a_nan = (a_exp == 8'hFF) && (a_frac != '0);
        b_nan = (b_exp == 8'hFF) && (b_frac != '0);
        a_inf = (a_exp == 8'hFF) && (a_frac == '0);
        b_inf = (b_exp == 8'hFF) && (b_frac == '0);

        // Exponent zero covers both true zero and flushed denormals
        a_ext = (a_exp == '0) ? '0 : {1'b1, a_frac, {GUARD_W{1'b0}}};
        b_ext = (b_exp == '0) ? '0 : {1'b1, b_frac, {GUARD_W{1'b0}}};

        sig_a_al = a_ext;
        sig_b_al = b_ext;
        if (a_exp >= b_exp) begin
            big_exp  = a_exp;
            exp_diff = a_exp - b_exp;
            sig_b_al = (exp_diff >= SW8) ? '0 : (b_ext >> exp_diff);
        end else begin
            big_exp  = b_exp;
            exp_diff = b_exp - a_exp;
            sig_a_al = (exp_diff >= SW8) ? '0 : (a_ext >> exp_diff);
        end

        spec_c      = SPEC_NONE;
        spec_sign_c = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            spec_c = SPEC_NAN;
        end else if (a_inf) begin
            spec_c      = SPEC_INF;
            spec_sign_c = a_sign;
        end else if (b_inf) begin
            spec_c      = SPEC_INF;
            spec_sign_c = b_sign;
        end
    end

    // ---------------- ADD ----------------
    always_comb begin
        if (al_sign_a == al_sign_b) begin
            add_mag  = {1'b0, al_sig_a} + {1'b0, al_sig_b};
            add_sign = al_sign_a;
        end else if (al_sig_a >= al_sig_b) begin
            add_mag  = {1'b0, al_sig_a} - {1'b0, al_sig_b};
            add_sign = al_sign_a;
        end else begin
            add_mag  = {1'b0, al_sig_b} - {1'b0, al_sig_a};
            add_sign = al_sign_b;
        end
    end

    // ---------------- NORM ----------------
    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int unsigned i = 0; i < SW; i++) begin
            if (!lz_found && sum_mag[SW-1-i]) begin
                lz       = LZ_W'(i);
                lz_found = 1'b1;
            end
        end

        if (sum_mag[SW]) begin
            norm_sig_c = sum_mag[SW:1];
            norm_exp_c = {2'b00, al_exp} + 10'd1;
        end else begin
            norm_sig_c = sum_mag[SW-1:0] << lz;
            norm_exp_c = {2'b00, al_exp} - 10'(lz);
        end

        // norm_exp_c is two's complement; bit 9 marks an underflowed exponent
        norm_zero_c  = (sum_mag == '0);
        norm_under_c = norm_exp_c[9] || (norm_exp_c == '0);
        norm_over_c  = !norm_exp_c[9] && (norm_exp_c >= 10'd255);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand      <= '0;
            al_sig_a     <= '0;
            al_sig_b     <= '0;
            al_sign_a    <= 1'b0;
            al_sign_b    <= 1'b0;
            al_exp       <= '0;
            al_spec      <= SPEC_NONE;
            al_spec_sign <= 1'b0;
            sum_mag      <= '0;
            sum_sign     <= 1'b0;
            nm_sig       <= '0;
            nm_exp       <= '0;
            nm_sign      <= 1'b0;
            nm_zero      <= 1'b0;
            nm_over      <= 1'b0;
            acc_out      <= '0;
            count        <= '0;
            ovf          <= 1'b0;
            nan_flag     <= 1'b0;
        end else if (clear) begin
            acc_out  <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            nan_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) operand <= in_data;
                end
                ALIGN: begin
                    al_sig_a     <= sig_a_al;
                    al_sig_b     <= sig_b_al;
                    al_sign_a    <= a_sign;
                    al_sign_b    <= b_sign;
                    al_exp       <= big_exp;
                    al_spec      <= spec_c;
                    al_spec_sign <= spec_sign_c;
                end
                ADD: begin
                    sum_mag  <= add_mag;
                    sum_sign <= add_sign;
                end
                NORM: begin
                    nm_sig  <= norm_sig_c;
                    nm_exp  <= norm_exp_c;
                    nm_sign <= sum_sign;
                    nm_zero <= norm_zero_c || norm_under_c;
                    nm_over <= norm_over_c;
                end
                WRITE: begin
                    if (count != '1) count <= count + 1'b1;
                    if (nan_flag || (al_spec == SPEC_NAN)) begin
                        acc_out  <= 32'h7FC0_0000;
                        nan_flag <= 1'b1;
                    end else if (al_spec == SPEC_INF) begin
                        acc_out <= {al_spec_sign, 8'hFF, 23'd0};
                    end else if (nm_zero) begin
                        acc_out <= '0;
                    end else if (nm_over) begin
                        acc_out <= {nm_sign, 8'hFF, 23'd0};
                        ovf     <= 1'b1;
                    end else begin
                        acc_out <= {nm_sign, nm_exp[7:0], nm_sig[SW-2 -: 23]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: accumulation, cancellation, overflow, NaN,
// clear and reset mid-operation, and count saturation on a COUNT_W=2 instance.
module tb_fp_accumulator;

    logic        clk = 1'b0;
    logic        rst, in_valid, clear;
    logic [31:0] in_data;

    logic        in_ready, busy, ovf, nan_flag;
    logic [31:0] acc_out;
    logic [7:0]  count;

    logic        sat_ready, sat_busy, sat_ovf, sat_nan;
    logic [31:0] sat_acc;
    logic [1:0]  sat_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_acc = '0;

    fp_accumulator #(.COUNT_W(8), .GUARD_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clear(clear), .acc_out(acc_out), .count(count),
        .busy(busy), .ovf(ovf), .nan_flag(nan_flag)
    );

    fp_accumulator #(.COUNT_W(2), .GUARD_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_ready),
        .in_data(in_data), .clear(clear), .acc_out(sat_acc), .count(sat_count),
        .busy(sat_busy), .ovf(sat_ovf), .nan_flag(sat_nan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One handshake; checks the 4-cycle busy window and the result at T+4
    task automatic send(input logic [31:0] w, input logic [31:0] exp_acc, input int exp_cnt);
        int waited = 0;
        while (!in_ready && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            check("ready_low", 32'(in_ready), 32'd0);
            check("busy_high", 32'(busy), 32'd1);
            if (k == 3) check("acc_before_write", acc_out, model_acc);
            @(posedge clk); #1;
        end
        model_acc = exp_acc;
        check("acc", acc_out, exp_acc);
        check("count", 32'(count), 32'(exp_cnt));
        check("sat_count", 32'(sat_count), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
        check("sat_acc", sat_acc, exp_acc);
        check("ready_after", 32'(in_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        check("ready_in_clear", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        model_acc = '0;
        check("clr_acc", acc_out, 32'h0);
        check("clr_count", 32'(count), 32'd0);
        check("clr_ovf", 32'(ovf), 32'd0);
        check("clr_nan", 32'(nan_flag), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0; in_data = '0;
        #2;
        check("rst_acc", acc_out, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_flags", {30'd0, ovf, nan_flag}, 32'd0);
        check("rst_sat_flags", {29'd0, sat_ovf, sat_nan, sat_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_pre_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_post_rst", 32'(in_ready), 32'd1);

        // 3.0 + 3.0
        send(32'h4040_0000, 32'h4040_0000, 1);
        send(32'h4040_0000, 32'h40C0_0000, 2);

        // cancellation and far-shift discard
        do_clear();
        send(32'h3F80_0000, 32'h3F80_0000, 1);
        send(32'hBF80_0000, 32'h0000_0000, 2);
        send(32'h3F80_0000, 32'h3F80_0000, 3);
        send(32'h3080_0000, 32'h3F80_0000, 4);

        // overflow then inf + -inf
        do_clear();
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1);
        check("ovf_clear", 32'(ovf), 32'd0);
        send(32'h7F7F_FFFF, 32'h7F80_0000, 2);
        check("ovf_set", 32'(ovf), 32'd1);
        check("nan_not_yet", 32'(nan_flag), 32'd0);
        send(32'hFF80_0000, 32'h7FC0_0000, 3);
        check("nan_set", 32'(nan_flag), 32'd1);

        // NaN stickiness
        do_clear();
        send(32'h7FC0_0001, 32'h7FC0_0000, 1);
        check("nan_in", 32'(nan_flag), 32'd1);
        send(32'h4040_0000, 32'h7FC0_0000, 2);
        do_clear();

        // clear mid-operation with a simultaneous in_valid
        send(32'h4040_0000, 32'h4040_0000, 1);
        in_valid = 1'b1; in_data = 32'h4040_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        model_acc = '0;
        check("midclr_busy", 32'(busy), 32'd0);
        check("midclr_acc", acc_out, 32'h0);
        @(posedge clk); #1;
        check("midclr_busy_t3", 32'(busy), 32'd0);
        check("midclr_count_t3", 32'(count), 32'd0);
        @(posedge clk); #1;
        check("midclr_acc_t4", acc_out, 32'h0);
        check("midclr_count_t4", 32'(count), 32'd0);

        // reset during NORM
        send(32'h4040_0000, 32'h4040_0000, 1);
        in_valid = 1'b1; in_data = 32'h3F80_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_acc", acc_out, 32'h0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_acc = '0;
        @(posedge clk); #1;
        check("arst_ready_after", 32'(in_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("arst_no_update", acc_out, 32'h0);
        check("arst_count_hold", 32'(count), 32'd0);

        // saturation of the COUNT_W=2 instance
        send(32'h3F80_0000, 32'h3F80_0000, 1);
        send(32'h3F80_0000, 32'h4000_0000, 2);
        send(32'h3F80_0000, 32'h4040_0000, 3);
        send(32'h3F80_0000, 32'h4080_0000, 4);
        send(32'h3F80_0000, 32'h40A0_0000, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Downstream consumer of the ALU's 32-bit IEEE-754 single-precision result word.
- Accepts one result per valid/ready handshake and adds it into a running single-precision sum using a multi-cycle FSM adder.
- Exposes the sum, a sample count and sticky status flags for readout or for chaining into later stages.
- Software-visible clear restarts accumulation.

Parameters:
- COUNT_W, 8, width of the accepted-sample counter; the counter saturates at 2^COUNT_W-1.
- GUARD_W, 2, number of guard bits kept below the 24-bit significand during alignment.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a valid IEEE-754 word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  IEEE-754 single-precision operand.
- clear  input  1  synchronous clear pulse.
- acc_out  output  32  current accumulated sum (IEEE-754).
- count  output  COUNT_W  number of operands folded into acc_out (saturating).
- busy  output  1  high whenever state is not IDLE.
- ovf  output  1  sticky: a finite sum overflowed to infinity.
- nan_flag  output  1  sticky: acc_out is NaN.

Behaviour:
- Reset (async, rst=1): state IDLE; acc_out=0x00000000, count=0, ovf=0, nan_flag=0, busy=0, in_ready=0 while rst is held.
  - in_ready=1 from the first clock edge after rst deasserts.
- Handshake: a transfer occurs only when in_valid & in_ready are both high at a rising edge.
  - in_ready = (state==IDLE) & ~clear.
  - in_data is captured on the handshake edge.
- FSM sequence: IDLE -> ALIGN -> ADD -> NORM -> WRITE -> IDLE, one cycle per state, no stalls.
  - ALIGN: unpack both operands and compare exponents; right-shift the smaller significand (24 bits plus GUARD_W zero guard bits). Bits shifted past the guard field are discarded. A shift of 24+GUARD_W or more makes that operand zero.
  - ADD: equal signs add magnitudes; unequal signs subtract the smaller from the larger magnitude, and the result takes the larger operand's sign.
  - NORM: single-cycle leading-zero normalize; a carry-out shifts right by 1 and increments the exponent.
  - WRITE: truncate to 23 fraction bits (round toward zero), pack, update acc_out, count+1 (saturating), then return to IDLE.
- Latency and throughput:
  - Handshake at edge T updates acc_out and count at edge T+4.
  - in_ready rises after edge T+4, so the earliest next handshake is edge T+5.
  - Throughput is 1 word per 5 cycles.
- Special values:
  - Denormal input or denormal result is treated as zero (flush-to-zero).
  - Exact cancellation gives +0 (0x00000000).
  - Exponent reaching 255 from finite operands gives signed infinity (0x7F800000 or 0xFF800000) and sets ovf.
  - Infinity plus finite gives that infinity; inf + inf of equal sign gives inf.
  - inf + (-inf), or any NaN input, gives acc_out=0x7FC00000 and sets nan_flag. Once nan_flag=1, acc_out stays 0x7FC00000 until clear or rst, while count still increments.
- clear, sampled at a rising edge:
  - Valid in any state; aborts any in-flight operation with no acc_out or count update.
  - Sets acc_out=0, count=0, ovf=0, nan_flag=0, state=IDLE.
  - in_ready is low in the clear cycle, so a simultaneous in_valid is not accepted.
- rst asserted mid-operation: immediate return to reset values; the in-flight operand is lost.
- in_data changes while not in_ready are ignored; there is no internal input buffering.

Test Plan:
- Accumulate 3.0: after reset, send 0x40400000 twice (second at T+5) -> acc_out 0x40400000 at T+4, then 0x40C00000 (6.0) at T+9; count=2; in_ready low for exactly 4 cycles after each handshake.
- Cancellation: send 0x3F800000 (1.0) then 0xBF800000 (-1.0) -> acc_out=0x00000000, count=2; then 0x3F800000 plus 0x30800000 (2^-30) -> acc_out stays 0x3F800000 (shift >= 26 discards the small operand).
- Overflow: send 0x7F7FFFFF twice -> acc_out=0x7F800000, ovf=1; then send 0xFF800000 -> acc_out=0x7FC00000, nan_flag=1.
- NaN stickiness: send 0x7FC00001 then 0x40400000 -> acc_out remains 0x7FC00000, count=2; pulse clear -> acc_out=0, count=0, all flags 0 on the next cycle.
- Clear mid-operation: handshake 0x40400000 at T, clear at T+2 with in_valid=1 -> no update at T+4, acc_out=0, count=0, busy=0 at T+3, the simultaneous word is not accepted.
- Reset mid-operation and saturation: rst pulse during NORM -> all outputs at reset values asynchronously; with COUNT_W=2, five accepted words -> count holds at 3.
